// File: rtl/car_traffic_pkg.sv
// Shared constants and types for the car traffic controller.
// Contents: lane geometry (y position, base speed, direction) for the five lanes,
//           lane/car counts, car size, and the lane direction type.
package car_traffic_pkg;

  localparam int NUM_LANES     = 5;
  localparam int CARS_PER_LANE = 2;
  localparam int CAR_SIZE      = 32;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_t;

  // Lane k owns cars 2k+1 and 2k+2.
  localparam logic [9:0] LANE_Y   [NUM_LANES] = '{10'd96, 10'd160, 10'd224, 10'd288, 10'd352};
  localparam logic [2:0] BASE_SPD [NUM_LANES] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd2};
  localparam dir_t       DIR      [NUM_LANES] = '{DIR_R, DIR_L, DIR_R, DIR_L, DIR_R};

endpackage

// File: rtl/car_lane.sv
// One traffic lane: two car x registers stepped once per frame tick with wrap-around.
// Ports: clk/rst, tick (one-cycle frame strobe), run, level, [jitter when CAR_JITTER_EN],
//        x_a/x_b (car left edges, registered), y (constant lane top edge).
// Optional: CAR_JITTER_EN adds a jitter offset to any car that wraps.
module car_lane
  import car_traffic_pkg::*;
#(
  parameter int         WRAP_W     = 672,
  parameter int         GAP        = 336,
  parameter logic [9:0] LANE_Y_P   = 10'd96,
  parameter logic [2:0] BASE_SPD_P = 3'd1,
  parameter dir_t       DIR_P      = DIR_R
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic [1:0] level,
`ifdef CAR_JITTER_EN
  input  logic [4:0] jitter,
`endif
  output logic [9:0] x_a,
  output logic [9:0] x_b,
  output logic [9:0] y
);

  localparam logic [10:0] WRAP = 11'(WRAP_W);

  logic [2:0]  spd;
  logic [9:0]  cur  [CARS_PER_LANE];
  logic [10:0] nxt  [CARS_PER_LANE];
  logic        wrap [CARS_PER_LANE];

  // Both cars share one speed, so their spacing mod WRAP_W never changes
  // (unless jitter nudges a wrapping car).
  assign spd    = BASE_SPD_P + {1'b0, level};
  assign cur[0] = x_a;
  assign cur[1] = x_b;
  assign y      = LANE_Y_P;

  always_comb begin
    for (int i = 0; i < CARS_PER_LANE; i++) begin
      nxt[i]  = 11'd0;
      wrap[i] = 1'b0;
      if (DIR_P == DIR_R) begin
        nxt[i]  = {1'b0, cur[i]} + {8'd0, spd};
        wrap[i] = (nxt[i] >= WRAP);
        if (wrap[i]) nxt[i] = nxt[i] - WRAP;
      end else begin
        wrap[i] = ({1'b0, cur[i]} < {8'd0, spd});
        nxt[i]  = wrap[i] ? ({1'b0, cur[i]} + WRAP - {8'd0, spd})
                          : ({1'b0, cur[i]} - {8'd0, spd});
      end
`ifdef CAR_JITTER_EN
      // Jitter pushes a wrapped car further from the wrap origin, then re-reduces.
      if (wrap[i]) begin
        if (DIR_P == DIR_R) begin
          nxt[i] = nxt[i] + {6'd0, jitter};
          if (nxt[i] >= WRAP) nxt[i] = nxt[i] - WRAP;
        end else begin
          nxt[i] = (nxt[i] < {6'd0, jitter}) ? (nxt[i] + WRAP - {6'd0, jitter})
                                             : (nxt[i] - {6'd0, jitter});
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_a <= 10'd0;
      x_b <= 10'(GAP);
    end else if (tick && run) begin
      x_a <= nxt[0][9:0];
      x_b <= nxt[1][9:0];
    end
  end

endmodule

// File: rtl/car_traffic_controller.sv
// Car position generator for the VGA game: ten cars in five lanes, stepped once per frame.
// Ports: clk/rst, vsync (frame strobe from vga_controller), run, level,
//        car_x1..10 / car_y1..10 (registered positions), frame_cnt (ticks while running).
// Optional: CAR_JITTER_EN enables a 16-bit LFSR that jitters cars as they wrap.
module car_traffic_controller
  import car_traffic_pkg::*;
#(
  parameter int WRAP_W = 672,
  parameter int GAP    = 336
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        run,
  input  logic [1:0]  level,
  output logic [9:0]  car_x1,
  output logic [9:0]  car_x2,
  output logic [9:0]  car_x3,
  output logic [9:0]  car_x4,
  output logic [9:0]  car_x5,
  output logic [9:0]  car_x6,
  output logic [9:0]  car_x7,
  output logic [9:0]  car_x8,
  output logic [9:0]  car_x9,
  output logic [9:0]  car_x10,
  output logic [9:0]  car_y1,
  output logic [9:0]  car_y2,
  output logic [9:0]  car_y3,
  output logic [9:0]  car_y4,
  output logic [9:0]  car_y5,
  output logic [9:0]  car_y6,
  output logic [9:0]  car_y7,
  output logic [9:0]  car_y8,
  output logic [9:0]  car_y9,
  output logic [9:0]  car_y10,
  output logic [15:0] frame_cnt
);

  localparam int NUM_CARS = NUM_LANES * CARS_PER_LANE;

  logic       vsync_d;
  logic       tick;
  logic [9:0] xs [NUM_CARS];
  logic [9:0] ys [NUM_CARS];

  // vsync_d resets high so a vsync already asserted at reset release
  // cannot fake a rising edge; a fresh 0->1 transition is required.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vsync_d <= 1'b1;
    else     vsync_d <= vsync;
  end

  assign tick = vsync & ~vsync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              frame_cnt <= 16'd0;
    else if (tick && run) frame_cnt <= frame_cnt + 16'd1;
  end

`ifdef CAR_JITTER_EN
  logic [15:0] lfsr;

  // Galois LFSR, advanced on every tick regardless of run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= 16'hACE1;
    else if (tick) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`endif

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    car_lane #(
      .WRAP_W     (WRAP_W),
      .GAP        (GAP),
      .LANE_Y_P   (LANE_Y[k]),
      .BASE_SPD_P (BASE_SPD[k]),
      .DIR_P      (DIR[k])
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .run    (run),
      .level  (level),
`ifdef CAR_JITTER_EN
      .jitter (lfsr[4:0]),
`endif
      .x_a    (xs[2*k]),
      .x_b    (xs[2*k+1]),
      .y      (ys[2*k])
    );
    assign ys[2*k+1] = ys[2*k];
  end

  assign car_x1  = xs[0];
  assign car_x2  = xs[1];
  assign car_x3  = xs[2];
  assign car_x4  = xs[3];
  assign car_x5  = xs[4];
  assign car_x6  = xs[5];
  assign car_x7  = xs[6];
  assign car_x8  = xs[7];
  assign car_x9  = xs[8];
  assign car_x10 = xs[9];
  assign car_y1  = ys[0];
  assign car_y2  = ys[1];
  assign car_y3  = ys[2];
  assign car_y4  = ys[3];
  assign car_y5  = ys[4];
  assign car_y6  = ys[5];
  assign car_y7  = ys[6];
  assign car_y8  = ys[7];
  assign car_y9  = ys[8];
  assign car_y10 = ys[9];

endmodule
